// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared opcodes, state encoding and divider result slices
package muldiv_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_DIV   = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_MULT  = 3'd3;
  localparam logic [2:0] OP_MULTU = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Divider result packing: {remainder, quotient}
  localparam int REM_MSB = 63;
  localparam int REM_LSB = 32;
  localparam int QUO_MSB = 31;
  localparam int QUO_LSB = 0;

endpackage

// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - combinational 32x32 -> 64 signed/unsigned multiplier
// Operands are extended to 64 bits; the low 64 bits of that product are exact for both signednesses.
module mult_unit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sign_i,
  output logic [63:0] prod_o
);

  logic [63:0] w_a;
  logic [63:0] w_b;

  assign w_a    = {{32{sign_i & a_i[31]}}, a_i};
  assign w_b    = {{32{sign_i & b_i[31]}}, b_i};
  assign prod_o = w_a * w_b;

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - EX-stage mul/div sequencer and HI/LO register owner
// Issues divides to the sibling iterative divider and stalls until its result is ready.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        ex_hold_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_valid_o,
  output logic        div_sign_o,
  output logic        div_flush_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  input  logic        div_busy_i,
  input  logic [63:0] div_result_i
);

  state_t      r_state;
  state_t      w_next;
  logic        r_first;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_stall;
  logic        w_valid;
  logic        w_flush;
  logic        w_wr_hi;
  logic        w_wr_lo;
  logic [31:0] w_hi_d;
  logic [31:0] w_lo_d;
  logic [63:0] w_prod;

  mult_unit u_mult (
    .a_i    (rs_i),
    .b_i    (rt_i),
    .sign_i (op_i == OP_MULT),
    .prod_o (w_prod)
  );

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_valid = 1'b0;
    w_flush = 1'b0;
    w_wr_hi = 1'b0;
    w_wr_lo = 1'b0;
    w_hi_d  = r_hi;
    w_lo_d  = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (!flush_i) begin
          case (op_i)
            OP_DIV, OP_DIVU: begin
              w_valid = 1'b1;
              w_stall = 1'b1;
              w_next  = ST_BUSY;
            end
            OP_MULT, OP_MULTU: begin
              w_wr_hi = !ex_hold_i;
              w_wr_lo = !ex_hold_i;
              w_hi_d  = w_prod[63:32];
              w_lo_d  = w_prod[31:0];
            end
            OP_MTHI: begin
              w_wr_hi = !ex_hold_i;
              w_hi_d  = rs_i;
            end
            OP_MTLO: begin
              w_wr_lo = !ex_hold_i;
              w_lo_d  = rs_i;
            end
            OP_NONE: ;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        // The divider raises busy one cycle after the start pulse, so the first BUSY cycle never completes.
        if (flush_i) begin
          w_flush = 1'b1;
          w_next  = ST_IDLE;
        end else if (r_first || div_busy_i) begin
          w_stall = 1'b1;
        end else begin
          w_wr_hi = 1'b1;
          w_wr_lo = 1'b1;
          w_hi_d  = div_result_i[REM_MSB:REM_LSB];
          w_lo_d  = div_result_i[QUO_MSB:QUO_LSB];
          w_next  = ex_hold_i ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: begin
        if (flush_i || !ex_hold_i) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_first <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      r_first <= w_valid;
      if (w_wr_hi) r_hi <= w_hi_d;
      if (w_wr_lo) r_lo <= w_lo_d;
    end
  end

  // Control strobes are forced low while reset is held, even if a DIV sits in EX.
  assign stall_o     = w_stall & resetn;
  assign div_valid_o = w_valid & resetn;
  assign div_flush_o = w_flush & resetn;
  assign div_sign_o  = (op_i == OP_DIV);
  assign div_a_o     = rs_i;
  assign div_b_o     = rt_i;
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the EX-stage multiply/divide unit and owner of the HI/LO architectural registers. Decodes the EX-stage mul/div opcode, launches the sibling 32-cycle iterative divider with a one-cycle start pulse, and stalls the pipeline until the quotient and remainder are available. Performs single-cycle MULT/MULTU and MTHI/MTLO writes, and aborts in-flight divides on pipeline flush.

## Interface
- No parameters. Opcode encodings come from the shared package.
- `clk`  in  1  Core clock, rising edge.
- `resetn`  in  1  Reset, asynchronous and active-low.
- `op_i`  in  3  EX opcode: NONE=0, DIV=1, DIVU=2, MULT=3, MULTU=4, MTHI=5, MTLO=6. Values 7 and above act as NONE.
- `rs_i`  in  32  Dividend, multiplicand, or MTHI/MTLO source.
- `rt_i`  in  32  Divisor or multiplier.
- `ex_hold_i`  in  1  EX stage is held by another stall source, so the instruction stays in EX.
- `flush_i`  in  1  Exception flush. Kills the instruction in EX.
- `stall_o`  out  1  Request to stall the pipeline (IF through EX).
- `hi_o`  out  32  HI register.
- `lo_o`  out  32  LO register.
- `div_valid_o`  out  1  Divider start pulse.
- `div_sign_o`  out  1  1 = signed divide.
- `div_flush_o`  out  1  Divider abort.
- `div_a_o`  out  32  Dividend to divider.
- `div_b_o`  out  32  Divisor to divider.
- `div_busy_i`  in  1  Divider is iterating.
- `div_result_i`  in  64  Divider output: {remainder, quotient}.

## Operation
- State machine: IDLE, BUSY, DONE. Reset value is IDLE, with HI=0, LO=0, and all outputs 0.
- IDLE:
  - DIV/DIVU with `flush_i`=0: `div_valid_o`=1 for exactly this cycle, `stall_o`=1, next state BUSY.
  - `div_sign_o` = (op==DIV). `div_a_o`=`rs_i` and `div_b_o`=`rt_i` are driven combinationally.
- BUSY:
  - `stall_o`=1 while `div_busy_i`=1.
  - The first cycle with `div_busy_i`=0 is the completion cycle. The one-cycle lag after the start pulse is masked: the first BUSY cycle always waits.
  - Completion cycle: HI ← `div_result_i[63:32]`, LO ← `div_result_i[31:0]`, `stall_o`=0.
  - Next state is DONE if `ex_hold_i`=1, otherwise IDLE.
- DONE:
  - `op_i` is ignored, so the held DIV is never re-issued. `stall_o`=0.
  - Return to IDLE on the first cycle with `ex_hold_i`=0.
- MULT/MULTU, in IDLE with `flush_i`=0 and `ex_hold_i`=0:
  - {HI,LO} ← 64-bit product, signed or unsigned. No stall.
  - While `ex_hold_i`=1 the write is suppressed, so a held MULT writes exactly once.
- MTHI/MTLO: same gating as MULT. HI or LO ← `rs_i`.
- Flush:
  - In IDLE: no issue and no write.
  - In BUSY: `div_flush_o`=1 for one cycle, no HI/LO write, next state IDLE, `stall_o`=0 in that cycle.
  - In DONE: next state IDLE.
- Divide by zero: the divider output is written unmodified. No trap.
- Resetn asserted mid-divide: the controller returns to IDLE immediately. Both outputs `div_valid_o` and `div_flush_o` are 0 during reset; the divider's own reset covers the divider.

## Timing
- DIV issue is cycle 0.
- Cycles 0..32: `stall_o`=1, which is 33 stall cycles.
- Cycle 33: completion cycle.
- HI/LO readable from cycle 34.
- MULT/MTHI/MTLO: HI/LO updated at the end of the issue cycle, visible on the next cycle.
- `stall_o` is combinational from state, `op_i`, `flush_i`, and `div_busy_i`. It has no path from `hi_o` or `lo_o`.
- HI/LO have a single write port. Only one write source can be active per cycle, by construction of the state machine.

## Structure
- Package `muldiv_pkg`: opcode localparams, state enum, result slice constants (REM = [63:32], QUO = [31:0]).
- One sub-module, `mult_unit`: combinational 32×32 → 64 signed/unsigned multiplier, selected by a sign input.
- The divider is a sibling instance wired at the EX stage and is not instantiated here.

## Test plan
- DIV with rs=0xFFFFFFF9 (−7), rt=2 → `div_valid_o` high exactly one cycle; `stall_o` high for 33 cycles; HI=0xFFFFFFFF and LO=0xFFFFFFFD in cycle 34.
- DIVU with rs=100, rt=7 and `ex_hold_i` high for 3 cycles after completion → HI=2, LO=14; `div_valid_o` pulses only once; state goes DONE then IDLE.
- MULT with rs=0xFFFFFFFE, rt=3 → next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=2, LO=0xFFFFFFFA. No stall in either case.
- DIV issued, `flush_i` at cycle 10 → `div_flush_o` pulse; HI/LO unchanged; `stall_o`=0 from cycle 10; a new DIV issues cleanly afterwards.
- MTHI rs=0x12345678 with `flush_i`=1 → HI unchanged. Repeat with `flush_i`=0 → HI=0x12345678.
- `resetn` low at cycle 15 of a divide → HI=0, LO=0, state IDLE, `stall_o`=0 immediately.
